// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine change dispenser.
// Amounts are counted in nickel units throughout.
package vend_pkg;

    localparam int DEFAULT_AMT_W         = 5;
    localparam int NICKEL_UNITS_PER_DIME = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } vend_state_t;

    typedef enum logic {
        COIN_DIME   = 1'b0,
        COIN_NICKEL = 1'b1
    } vend_coin_t;

endpackage

// File: rtl/vend_pulse_timer.sv
// Loadable down-counter with a terminal-count flag.
// One instance times both the eject pulse and the low gap that follows it.
module vend_pulse_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_tc
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: turns a change amount into paced dime/nickel eject pulses,
// dimes first, falling back to nickels, and flags any unpaid remainder.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W        = DEFAULT_AMT_W,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             dime_empty,
    input  logic             nickel_empty,
    output logic             dime_pulse,
    output logic             nickel_pulse,
    output logic             busy,
    output logic             done,
    output logic             shortfall,
    output logic [AMT_W-1:0] remaining
);

    localparam int MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] DIME_UNITS = AMT_W'(NICKEL_UNITS_PER_DIME);

    vend_state_t      r_state, w_state_next;
    vend_coin_t       r_coin, w_coin_next;
    logic [AMT_W-1:0] r_remaining, w_remaining_next;
    logic             r_shortfall, w_shortfall_next;
    logic             r_dime_pulse, r_nickel_pulse;
    logic             w_tmr_load;
    logic [TW-1:0]    w_tmr_val;
    logic             w_tmr_tc;

    vend_pulse_timer #(
        .TW (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_coin         <= COIN_DIME;
            r_remaining    <= '0;
            r_shortfall    <= 1'b0;
            r_dime_pulse   <= 1'b0;
            r_nickel_pulse <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_coin         <= w_coin_next;
            r_remaining    <= w_remaining_next;
            r_shortfall    <= w_shortfall_next;
            // Pulse drives come straight from flops so the hopper pins never glitch.
            r_dime_pulse   <= (w_state_next == ST_PULSE) && (w_coin_next == COIN_DIME);
            r_nickel_pulse <= (w_state_next == ST_PULSE) && (w_coin_next == COIN_NICKEL);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_coin_next      = r_coin;
        w_remaining_next = r_remaining;
        w_shortfall_next = r_shortfall;
        w_tmr_load       = 1'b0;
        w_tmr_val        = '0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next     = ST_SELECT;
                    w_remaining_next = req_amount;
                    w_shortfall_next = 1'b0;
                end
            end
            ST_SELECT: begin
                if (r_remaining == '0) begin
                    w_state_next     = ST_DONE;
                    w_shortfall_next = 1'b0;
                end else if (r_remaining >= DIME_UNITS && !dime_empty) begin
                    w_state_next = ST_PULSE;
                    w_coin_next  = COIN_DIME;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PULSE_LOAD;
                end else if (!nickel_empty) begin
                    w_state_next = ST_PULSE;
                    w_coin_next  = COIN_NICKEL;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PULSE_LOAD;
                end else begin
                    w_state_next     = ST_DONE;
                    w_shortfall_next = 1'b1;
                end
            end
            ST_PULSE: begin
                if (w_tmr_tc) begin
                    w_state_next     = ST_GAP;
                    w_tmr_load       = 1'b1;
                    w_tmr_val        = GAP_LOAD;
                    w_remaining_next = (r_coin == COIN_DIME) ? r_remaining - DIME_UNITS
                                                             : r_remaining - 1'b1;
                end
            end
            ST_GAP: begin
                if (w_tmr_tc) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_DONE: begin
                w_state_next     = ST_IDLE;
                w_shortfall_next = 1'b0;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign busy         = (r_state != ST_IDLE);
    assign req_ready    = !busy;
    assign done         = (r_state == ST_DONE);
    assign shortfall    = r_shortfall;
    assign remaining    = r_remaining;
    assign dime_pulse   = r_dime_pulse;
    assign nickel_pulse = r_nickel_pulse;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Randomized bench for the change dispenser: every cycle of each request is
// compared against a coin-count/latency model derived from the greedy rules.
module tb_vend_change_dispenser;

    localparam int AMT_W = 5;
    localparam int P     = 2;
    localparam int G     = 1;
    localparam int C     = P + G + 1;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             dime_empty;
    logic             nickel_empty;
    logic             dime_pulse;
    logic             nickel_pulse;
    logic             busy;
    logic             done;
    logic             shortfall;
    logic [AMT_W-1:0] remaining;

    int n_checks;
    int n_errors;

    vend_change_dispenser #(
        .AMT_W        (AMT_W),
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_amount   (req_amount),
        .req_ready    (req_ready),
        .dime_empty   (dime_empty),
        .nickel_empty (nickel_empty),
        .dime_pulse   (dime_pulse),
        .nickel_pulse (nickel_pulse),
        .busy         (busy),
        .done         (done),
        .shortfall    (shortfall),
        .remaining    (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Handshake at a rising edge (cycle 0); returns after the posedge.
    task automatic handshake(input int amt);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("req_ready_before_req", req_ready, 1);
        req_valid  = 1'b1;
        req_amount = AMT_W'(amt);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_amount = '0;
    endtask

    task automatic run_txn(input int amt, input bit de, input bit ne);
        int d, n, coins, rem, exp_done, exp_sf;
        int idx, j, off, paid, pd, pn, exp_rem;
        int e_dp, e_np, n_dp_seen, n_np_seen;
        // Greedy model: as many dimes as fit if dimes available, rest in nickels.
        d        = de ? 0 : amt / 2;
        rem      = amt - 2 * d;
        n        = ne ? 0 : rem;
        rem      = rem - n;
        exp_sf   = (rem != 0) ? 1 : 0;
        coins    = d + n;
        exp_done = 2 + coins * C;
        n_dp_seen = 0;
        n_np_seen = 0;

        dime_empty   = de;
        nickel_empty = ne;
        handshake(amt);
        for (int k = 1; k <= exp_done; k++) begin
            @(negedge clk);
            e_dp = 0;
            e_np = 0;
            if (k >= 2) begin
                idx = k - 2;
                j   = idx / C;
                off = idx % C;
                if (j < coins && off < P) begin
                    if (j < d) e_dp = 1;
                    else       e_np = 1;
                end
            end
            paid = (k >= 2 + P) ? (k - 2 - P) / C + 1 : 0;
            if (paid > coins) paid = coins;
            pd = (paid < d) ? paid : d;
            pn = paid - pd;
            exp_rem = amt - 2 * pd - pn;
            chk("dime_pulse", dime_pulse, e_dp);
            chk("nickel_pulse", nickel_pulse, e_np);
            chk("done", done, (k == exp_done) ? 1 : 0);
            chk("busy", busy, 1);
            chk("remaining", remaining, exp_rem);
            if (dime_pulse && nickel_pulse) chk("both_pulses", 1, 0);
            n_dp_seen += dime_pulse ? 1 : 0;
            n_np_seen += nickel_pulse ? 1 : 0;
            if (k == exp_done) chk("shortfall", shortfall, exp_sf);
        end
        @(negedge clk);
        chk("req_ready_after", req_ready, 1);
        chk("done_after", done, 0);
        chk("remaining_kept", remaining, rem);
        $display("TXN amt=%0d dime_empty=%0d nickel_empty=%0d dimes=%0d nickels=%0d shortfall=%0d remaining=%0d",
                 amt, de, ne, n_dp_seen / P, n_np_seen / P, exp_sf, rem);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_amount   = '0;
        dime_empty   = 1'b0;
        nickel_empty = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_shortfall", shortfall, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_dime_pulse", dime_pulse, 0);
        chk("rst_nickel_pulse", nickel_pulse, 0);
        rst_n = 1'b1;

        run_txn(3, 1'b0, 1'b0);
        run_txn(4, 1'b1, 1'b0);
        run_txn(3, 1'b0, 1'b1);
        run_txn(0, 1'b0, 1'b0);
        run_txn(31, 1'b0, 1'b0);
        run_txn(1, 1'b1, 1'b1);
        run_txn(5, 1'b1, 1'b1);

        // Asynchronous reset in the middle of a dime pulse.
        dime_empty   = 1'b0;
        nickel_empty = 1'b0;
        handshake(6);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_dime_pulse", dime_pulse, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_dime_pulse", dime_pulse, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_req_ready", req_ready, 1);
        chk("async_rst_remaining", remaining, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_remaining", remaining, 0);
        $display("TXN async reset mid-pulse amt=6");
        run_txn(6, 1'b0, 1'b0);

        for (int t = 0; t < 30; t++) begin
            run_txn(int'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
